unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
// - Shares one single-port unified instruction/data memory between the fetch side and the MEM stage.
// - Fetch side: IF stage, instruction fetch at pc_next. Data side: MEM stage, ALU result address, MemRW and forwarded store data.
// - Serialises accesses and allows one outstanding transaction. Returns read data or write completion to the winner.
// - Bounds every access with a timeout. The pipeline stalls on the *_req & ~*_done condition.
// PARAMETERS
// - AW            32   address width
// - DW            32   data width (word access only)
// - TIMEOUT_CYC   255  maximum cycles waiting for mem_ack before an error completion; range 1..65535
// - MAX_D_STREAK  4    consecutive data grants before a forced fetch grant (only with ARB_STARVE_GUARD_EN)
// PORTS
// - clk        in   1   rising-edge clock
// - rst        in   1   asynchronous reset, active-high
// - i_req      in   1   fetch request; held until i_done
// - i_addr     in   AW  fetch address; stable while i_req
// - i_done     out  1   one-cycle pulse: fetch complete, i_rdata valid
// - i_rdata    out  DW  fetched instruction; held until the next i_done
// - d_req      in   1   data request; held until d_done
// - d_we       in   1   1 = store, 0 = load
// - d_addr     in   AW  data address
// - d_wdata    in   DW  store data
// - d_done     out  1   one-cycle pulse: data access complete
// - d_rdata    out  DW  load data; 0 for stores
// - mem_req    out  1   one-cycle command strobe to memory
// - mem_we     out  1   write command
// - mem_addr   out  AW  command address
// - mem_wdata  out  DW  command write data
// - mem_ack    in   1   memory completion; read data is valid with it
// - mem_rdata  in   DW  memory read data
// - err        out  1   one-cycle pulse with the *_done of a timed-out access
// - busy       out  1   1 when the FSM is not in IDLE
// BEHAVIOUR
// - Reset values: all outputs 0, FSM in IDLE, owner = fetch, streak counter 0.
// - Reset is asynchronous. Asserting it mid-transaction aborts the access; no done pulse is generated.
// - FSM states:
//   - IDLE: if any request is present, latch the winner's command and owner, then go to ISSUE.
//   - ISSUE: mem_req = 1 for exactly one cycle, mem_* driven from the latched registers. Go to WAIT.
//     - mem_ack in ISSUE is ignored; memory latency is at least 1 cycle.
//   - WAIT:
//     - On mem_ack: capture mem_rdata and go to RESP.
//     - On no ack: increment the timeout counter. When it reaches TIMEOUT_CYC, go to RESP with error flagged.
//   - RESP: pulse the owner's done, plus err if flagged. Update the owner's rdata. Return to IDLE.
//     - Error and write completions return rdata = 0.
// - Arbitration (IDLE only), when both requests are present: data wins. The data access is the older instruction.
// - Latency: request seen in IDLE at cycle 0 -> mem_req at cycle 1 -> mem_ack at cycle 1+L -> done at cycle 2+L.
//   - Minimum is 3 cycles (L = 1).
// - Back-to-back: a requester deasserts req or changes its address in the cycle after done.
//   - A req still high when IDLE is re-entered is a new request.
// - A mem_ack arriving in IDLE or RESP (late ack after a timeout) is ignored. It does not corrupt the next transaction.
// - Request inputs are sampled only in IDLE. Changes during ISSUE/WAIT/RESP have no effect.
// - Timeout counter: width $clog2(TIMEOUT_CYC+1). Cleared on entry to ISSUE. No wrap; it saturates at TIMEOUT_CYC.
// - mem_addr, mem_we and mem_wdata come from registers and hold their value outside ISSUE.
// CONFIGURATION
// - Macro: ARB_STARVE_GUARD_EN
// - Defined:
//   - A streak counter counts consecutive data grants; a fetch grant clears it.
//   - When the counter equals MAX_D_STREAK and both requests are present, fetch wins and the counter clears.
//   - Counter width is $clog2(MAX_D_STREAK+1).
// - Undefined: strict data priority; no streak counter is instantiated.
// TESTING
// - Single fetch, addr 0x10, mem_ack 2 cycles after mem_req, rdata 0x00500093 -> i_done at cycle 4, i_rdata = 0x00500093, err = 0.
// - d_req store (addr 0x40, wdata 0xDEADBEEF) and i_req raised in the same cycle:
//   - -> data issued first: mem_we = 1, mem_addr = 0x40.
//   - -> d_done, then fetch issued; d_rdata = 0.
// - mem_ack never returns, TIMEOUT_CYC = 8 -> d_done and err pulse together 10 cycles after the request.
//   - -> d_rdata = 0.
//   - -> a late ack in IDLE is ignored; the next fetch completes normally.
// - rst pulsed during WAIT -> mem_req, busy and done are 0 immediately; the FSM is in IDLE; a later request completes normally.
// - With ARB_STARVE_GUARD_EN, MAX_D_STREAK = 4, both requests held continuously -> grant sequence D,D,D,D,I,D,D,D,D,I.
//   - Without the macro -> data is granted every time.
// - Latency sweep L = 1..5 and back-to-back fetches -> done exactly 2+L cycles after each IDLE request; no lost or duplicated done.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and MEM-stage data accesses.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module unified_mem_arbiter #(
   parameter int unsigned AW           = 32,
   parameter int unsigned DW           = 32,
   parameter int unsigned TIMEOUT_CYC  = 255,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_done,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_done,
   output logic [DW-1:0] d_rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic          err,
   output logic          busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e        state_q;
   logic          owner_d_q;
   logic [TW-1:0] tmo_q;
   logic [TW-1:0] tmo_next;
   logic          grant_d;
   logic          any_req;

   assign any_req  = i_req | d_req;
   assign tmo_next = tmo_q + 1'b1;
   assign busy     = (state_q != StIdle);

`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);

   logic [SW-1:0] streak_q;

   // After SMAX consecutive data grants a contending fetch gets one turn.
   always_comb begin
      grant_d = d_req & ~(i_req & (streak_q == SMAX));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         streak_q <= '0;
      end else if (state_q == StIdle && any_req) begin
         if (!grant_d) begin
            streak_q <= '0;
         end else if (streak_q != SMAX) begin
            streak_q <= streak_q + 1'b1;
         end
      end
   end
`else
   always_comb begin
      grant_d = d_req;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         owner_d_q <= 1'b0;
         tmo_q     <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_done    <= 1'b0;
         i_rdata   <= '0;
         d_done    <= 1'b0;
         d_rdata   <= '0;
         err       <= 1'b0;
      end else begin
         mem_req <= 1'b0;
         i_done  <= 1'b0;
         d_done  <= 1'b0;
         err     <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (any_req) begin
                  owner_d_q <= grant_d;
                  mem_we    <= grant_d & d_we;
                  mem_addr  <= grant_d ? d_addr : i_addr;
                  mem_wdata <= grant_d ? d_wdata : '0;
                  tmo_q     <= '0;
                  mem_req   <= 1'b1;
                  state_q   <= StIssue;
               end
            end
            StIssue: begin
               state_q <= StWait;
            end
            StWait: begin
               // Done/rdata are set on the way into RESP so they are visible there.
               if (mem_ack || tmo_next == TMAX) begin
                  state_q <= StResp;
                  err     <= ~mem_ack;
                  if (owner_d_q) begin
                     d_done  <= 1'b1;
                     d_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                  end else begin
                     i_done  <= 1'b1;
                     i_rdata <= mem_ack ? mem_rdata : '0;
                  end
               end else begin
                  tmo_q <= tmo_next;
               end
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a latency-programmable memory model.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic        i_done, d_done, mem_req, mem_we, err, busy;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic        mem_ack   = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int          mdl_lat    = 1;
   logic [31:0] mdl_rdata  = 32'h0;
   bit          mdl_noack  = 1'b0;
   int          mdl_cnt    = 0;
   int          inj_req    = 0;
   int          inj_seen   = 0;

   unified_mem_arbiter #(
      .AW(32), .DW(32), .TIMEOUT_CYC(8), .MAX_D_STREAK(4)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: ack is high for the single cycle L cycles after the mem_req cycle.
   always @(posedge clk) begin
      #1;
      mem_ack = 1'b0;
      if (rst) begin
         mdl_cnt = 0;
      end else begin
         if (inj_req != inj_seen) begin
            inj_seen  = inj_req;
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0BAD0;
         end
         if (mdl_cnt > 0) begin
            mdl_cnt = mdl_cnt - 1;
            if (mdl_cnt == 0) begin
               mem_ack   = 1'b1;
               mem_rdata = mdl_rdata;
            end
         end
         if (mem_req && !mdl_noack) mdl_cnt = mdl_lat;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // which: 0 mem_req, 1 d_done, 2 i_done, 3 any done
   task automatic wait_for(input int which, input int bound, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if ((which == 0 && mem_req) || (which == 1 && d_done) ||
             (which == 2 && i_done) || (which == 3 && (i_done || d_done))) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_%0d: no event within %0d cycles (t=%0t)", which, bound, $time);
      end
   endtask

   typedef struct {
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
      bit          hold;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[8];

   task automatic do_access(input vec_t v, input bit b2b, input string name);
      int start;
      bit ok;
      mdl_lat   = v.lat;
      mdl_rdata = v.rdata;
      mdl_noack = 1'b0;
      i_req     = !v.is_d;
      d_req     = v.is_d;
      d_we      = v.we;
      if (v.is_d) begin
         d_addr  = v.addr;
         d_wdata = v.wdata;
      end else begin
         i_addr = v.addr;
      end
      // A held request re-enters arbitration in the IDLE cycle after RESP.
      start = b2b ? cyc + 1 : cyc;
      wait_for(0, 10, ok);
      if (ok) begin
         chk({name, "_mem_addr"}, mem_addr, v.addr);
         chk({name, "_mem_we"}, {31'b0, mem_we}, {31'b0, v.is_d & v.we});
         if (v.is_d && v.we) chk({name, "_mem_wdata"}, mem_wdata, v.wdata);
      end
      wait_for(3, 20, ok);
      if (ok) begin
         chk({name, "_done_owner"}, {30'b0, d_done, i_done}, {30'b0, v.is_d, !v.is_d});
         chk({name, "_latency"}, cyc - start, 2 + v.lat);
         chk({name, "_rdata"}, v.is_d ? d_rdata : i_rdata, v.exp_rdata);
         chk({name, "_err"}, {31'b0, err}, 32'h0);
      end
      if (!v.hold) begin
         i_req = 1'b0;
         d_req = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ok;
      int          start;
      bit          prev_hold;
      vec_t        v;
      logic [31:0] exp_g;

      //            is_d we addr          wdata         rdata         lat hold exp_rdata
      vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'h00500093, 2, 1'b1, 32'h00500093};
      vecs[1] = '{1'b0, 1'b0, 32'h14,  32'h0,        32'h11110001, 1, 1'b1, 32'h11110001};
      vecs[2] = '{1'b0, 1'b0, 32'h18,  32'h0,        32'h22220002, 3, 1'b1, 32'h22220002};
      vecs[3] = '{1'b0, 1'b0, 32'h1C,  32'h0,        32'h33330003, 4, 1'b1, 32'h33330003};
      vecs[4] = '{1'b0, 1'b0, 32'h20,  32'h0,        32'h44440004, 5, 1'b0, 32'h44440004};
      vecs[5] = '{1'b1, 1'b0, 32'h300, 32'h0,        32'hCAFEF00D, 1, 1'b1, 32'hCAFEF00D};
      vecs[6] = '{1'b1, 1'b1, 32'h304, 32'h12345678, 32'hFFFFFFFF, 2, 1'b1, 32'h0};
      vecs[7] = '{1'b1, 1'b0, 32'h308, 32'h0,        32'hA5A5A5A5, 3, 1'b0, 32'hA5A5A5A5};

      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
      repeat (2) @(negedge clk);
      chk("reset_strobes", {26'b0, mem_req, mem_we, i_done, d_done, err, busy}, 32'h0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_mem_wdata", mem_wdata, 32'h0);
      chk("reset_i_rdata", i_rdata, 32'h0);
      chk("reset_d_rdata", d_rdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Fetch latency sweep with back-to-back requests, then data loads/stores.
      prev_hold = 1'b0;
      for (int n = 0; n < 8; n++) begin
         do_access(vecs[n], prev_hold, $sformatf("vec%0d", n));
         prev_hold = vecs[n].hold;
      end

      // Simultaneous store and fetch: data first.
      mdl_lat = 1; mdl_rdata = 32'h11111111;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
      i_req = 1'b1; i_addr = 32'h44;
      wait_for(0, 10, ok);
      chk("arb_first_we", {31'b0, mem_we}, 32'h1);
      chk("arb_first_addr", mem_addr, 32'h40);
      chk("arb_first_wdata", mem_wdata, 32'hDEADBEEF);
      wait_for(3, 20, ok);
      chk("arb_d_done", {30'b0, d_done, i_done}, 32'h2);
      chk("arb_d_rdata", d_rdata, 32'h0);
      d_req = 1'b0; d_we = 1'b0;
      mdl_rdata = 32'h00A00113;
      wait_for(0, 10, ok);
      chk("arb_second_addr", mem_addr, 32'h44);
      chk("arb_second_we", {31'b0, mem_we}, 32'h0);
      wait_for(3, 20, ok);
      chk("arb_i_done", {30'b0, d_done, i_done}, 32'h1);
      chk("arb_i_rdata", i_rdata, 32'h00A00113);
      i_req = 1'b0;
      @(negedge clk);

      // Timeout: no ack ever returns.
      mdl_noack = 1'b1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
      start = cyc;
      wait_for(3, 30, ok);
      chk("tmo_latency", cyc - start, 32'd10);
      chk("tmo_done_err", {29'b0, d_done, i_done, err}, 32'h5);
      chk("tmo_d_rdata", d_rdata, 32'h0);
      d_req = 1'b0;
      mdl_noack = 1'b0;
      inj_req++;
      @(negedge clk);
      chk("tmo_err_pulse", {31'b0, err}, 32'h0);
      @(negedge clk);
      chk("late_ack_idle", {30'b0, busy, mem_req}, 32'h0);
      v = '{1'b0, 1'b0, 32'h50, 32'h0, 32'h00C00193, 1, 1'b0, 32'h00C00193};
      do_access(v, 1'b0, "post_tmo");

      // Reset during WAIT aborts the fetch.
      mdl_lat = 5; i_req = 1'b1; i_addr = 32'h60;
      wait_for(0, 10, ok);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_wait_strobes", {27'b0, mem_req, busy, i_done, d_done, err}, 32'h0);
      i_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      v = '{1'b0, 1'b0, 32'h64, 32'h0, 32'h0040006F, 2, 1'b0, 32'h0040006F};
      do_access(v, 1'b0, "post_rst");

      // Both requests held continuously.
      mdl_lat = 1; mdl_rdata = 32'h0;
      i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      for (int g = 0; g < 10; g++) begin
         wait_for(0, 20, ok);
`ifdef ARB_STARVE_GUARD_EN
         exp_g = (g == 4 || g == 9) ? 32'h100 : 32'h200;
`else
         exp_g = 32'h200;
`endif
         if (ok) chk($sformatf("streak_grant%0d", g), mem_addr, exp_g);
      end
      i_req = 1'b0; d_req = 1'b0;
      repeat (8) @(negedge clk);
      chk("final_idle", {31'b0, busy}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
